// File: rtl/css_pkg.sv
// Shared types and constants for the pipelined 16-bit carry-select subtractor.
// CSS_SIGNED_OVF_EN adds the operand sign bits to the stage-1 payload.
package css_pkg;

  localparam int CSS_WIDTH = 16;
  localparam int CSS_BLK   = 4;
  localparam int CSS_HALF  = 8;

  typedef logic [CSS_WIDTH-1:0] css_word_t;

  // Stage-1 payload: finished low byte plus what the high byte still needs
  typedef struct packed {
    logic [CSS_HALF-1:0] lo_diff;
    logic                carry;
    logic [CSS_HALF-1:0] a_hi;
    logic [CSS_HALF-1:0] nb_hi;
`ifdef CSS_SIGNED_OVF_EN
    logic                a_sign;
    logic                b_sign;
`endif
  } css_s1_t;

endpackage

// File: rtl/css_select_block.sv
// BLK-bit carry-select cell: two ripple chains (carry-in 0 and 1) resolved by
// the real incoming carry through an output mux.
module css_select_block
  import css_pkg::*;
#(
  parameter int BLK = CSS_BLK
) (
  input  logic [BLK-1:0] x,
  input  logic [BLK-1:0] y,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);

  logic [BLK-1:0] sum0;
  logic [BLK-1:0] sum1;
  logic           c0;
  logic           c1;

  always_comb begin
    sum0 = '0;
    sum1 = '0;
    c0   = 1'b0;
    c1   = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      sum0[i] = x[i] ^ y[i] ^ c0;
      c0      = (x[i] & y[i]) | (c0 & (x[i] ^ y[i]));
      sum1[i] = x[i] ^ y[i] ^ c1;
      c1      = (x[i] & y[i]) | (c1 & (x[i] ^ y[i]));
    end
  end

  assign s    = cin ? sum1 : sum0;
  assign cout = cin ? c1 : c0;

endmodule

// File: rtl/carry_select_subtractor_16bit.sv
// Two-stage carry-select subtractor diff = a - b - bin with valid/ready on both
// sides. Define CSS_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module carry_select_subtractor_16bit
  import css_pkg::*;
#(
  parameter int WIDTH = CSS_WIDTH,
  parameter int BLK   = CSS_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSS_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = CSS_HALF / BLK;

  if ((WIDTH != CSS_WIDTH) || ((WIDTH % (2 * BLK)) != 0)) begin : g_param_check
    $error("carry_select_subtractor_16bit: WIDTH must be 16 and a multiple of 2*BLK");
  end

  logic    s1_valid;
  logic    s2_valid;
  logic    s2_free;
  logic    s1_adv;
  logic    accept;
  css_s1_t s1_q;
  css_s1_t s1_d;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // ---- stage 1: low byte, a + ~b with carry-in ~bin ----
  logic [CSS_HALF-1:0] lo_nb;
  logic [CSS_HALF-1:0] lo_s;
  logic [NBLK:0]       lo_c;

  assign lo_nb   = ~b[CSS_HALF-1:0];
  assign lo_c[0] = ~bin;

  for (genvar i = 0; i < NBLK; i++) begin : g_lo
    css_select_block #(.BLK(BLK)) u_blk (
      .x    (a[i*BLK +: BLK]),
      .y    (lo_nb[i*BLK +: BLK]),
      .cin  (lo_c[i]),
      .s    (lo_s[i*BLK +: BLK]),
      .cout (lo_c[i+1])
    );
  end

  always_comb begin
    s1_d         = '0;
    s1_d.lo_diff = lo_s;
    s1_d.carry   = lo_c[NBLK];
    s1_d.a_hi    = a[WIDTH-1:CSS_HALF];
    s1_d.nb_hi   = ~b[WIDTH-1:CSS_HALF];
`ifdef CSS_SIGNED_OVF_EN
    s1_d.a_sign  = a[WIDTH-1];
    s1_d.b_sign  = b[WIDTH-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---- stage 2: high byte selected by the registered low-byte carry ----
  logic [CSS_HALF-1:0] hi_s;
  logic [NBLK:0]       hi_c;
  css_word_t           diff_next;

  assign hi_c[0] = s1_q.carry;

  for (genvar i = 0; i < NBLK; i++) begin : g_hi
    css_select_block #(.BLK(BLK)) u_blk (
      .x    (s1_q.a_hi[i*BLK +: BLK]),
      .y    (s1_q.nb_hi[i*BLK +: BLK]),
      .cin  (hi_c[i]),
      .s    (hi_s[i*BLK +: BLK]),
      .cout (hi_c[i+1])
    );
  end

  assign diff_next = {hi_s, s1_q.lo_diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef CSS_SIGNED_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      diff     <= diff_next;
      bout     <= ~hi_c[NBLK];
`ifdef CSS_SIGNED_OVF_EN
      ovf      <= (s1_q.a_sign != s1_q.b_sign) && (diff_next[WIDTH-1] != s1_q.a_sign);
`endif
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor_16bit.sv
// Directed and randomized bench for carry_select_subtractor_16bit; build with
// +define+CSS_SIGNED_OVF_EN to also check the ovf output.
module tb_carry_select_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        bout;
`ifdef CSS_SIGNED_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [15:0] q_diff[$];
  logic        q_bout[$];
  logic        q_ovf[$];
  int          q_cyc[$];

  logic [15:0] e_diff[$];
  logic        e_bout[$];
  logic        e_ovf[$];

  logic drv_done;

  carry_select_subtractor_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CSS_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result handshake; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_diff.push_back(diff);
      q_bout.push_back(bout);
`ifdef CSS_SIGNED_OVF_EN
      q_ovf.push_back(ovf);
`else
      q_ovf.push_back(1'b0);
`endif
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_diff.delete();
    q_bout.delete();
    q_ovf.delete();
    q_cyc.delete();
  endtask

  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
    int waits = 0;
    a = va;
    b = vb;
    bin = vbin;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check_val("send_in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (q_diff.size() < n && k < budget) begin
      k++;
      @(posedge clk);
    end
    #1;
    check_val("result_count", q_diff.size(), n);
  endtask

  initial begin
    // ---- reset state ----
    #12;
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_diff", {16'b0, diff}, 32'h0);
    check_val("rst_bout", {31'b0, bout}, 32'd0);
    check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ---- 7 - 3: exact two-cycle latency ----
    a = 16'd7; b = 16'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("lat1_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("lat2_out_valid", {31'b0, out_valid}, 32'd1);
    check_val("lat2_diff", {16'b0, diff}, 32'h0004);
    check_val("lat2_bout", {31'b0, bout}, 32'd0);
    @(posedge clk);
    #1;

    // ---- back-to-back: 5-6-1 then 0-1 ----
    clear_q();
    send(16'd5, 16'd6, 1'b1);
    send(16'd0, 16'd1, 1'b0);
    wait_results(2, 20);
    if (q_diff.size() == 2) begin
      check_val("b2b_diff0", {16'b0, q_diff[0]}, 32'hFFFE);
      check_val("b2b_bout0", {31'b0, q_bout[0]}, 32'd1);
      check_val("b2b_diff1", {16'b0, q_diff[1]}, 32'hFFFF);
      check_val("b2b_bout1", {31'b0, q_bout[1]}, 32'd1);
      check_val("b2b_spacing", q_cyc[1] - q_cyc[0], 32'd1);
    end

    // ---- wrap-around and signed overflow corners ----
    clear_q();
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h8000, 16'h0001, 1'b0);
    wait_results(2, 20);
    if (q_diff.size() == 2) begin
      check_val("wrap_diff", {16'b0, q_diff[0]}, 32'hFFFF);
      check_val("wrap_bout", {31'b0, q_bout[0]}, 32'd1);
      check_val("min_diff", {16'b0, q_diff[1]}, 32'h7FFF);
      check_val("min_bout", {31'b0, q_bout[1]}, 32'd0);
`ifdef CSS_SIGNED_OVF_EN
      check_val("wrap_ovf", {31'b0, q_ovf[0]}, 32'd0);
      check_val("min_ovf", {31'b0, q_ovf[1]}, 32'd1);
`endif
    end

    // ---- backpressure: 4 beats, output stalled after first result ----
    clear_q();
    out_ready = 1'b0;
    fork
      begin
        send(16'd10, 16'd1, 1'b0);
        send(16'd20, 16'd2, 1'b0);
        send(16'd30, 16'd3, 1'b0);
        send(16'd40, 16'd4, 1'b0);
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
          k++;
          @(negedge clk);
        end
        check_val("bp_first_valid", {31'b0, out_valid}, 32'd1);
        for (int s = 0; s < 3; s++) begin
          check_val("bp_hold_valid", {31'b0, out_valid}, 32'd1);
          check_val("bp_hold_diff", {16'b0, diff}, 32'h0009);
          check_val("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_results(4, 40);
    repeat (5) @(posedge clk);
    #1;
    check_val("bp_no_dup", q_diff.size(), 32'd4);
    if (q_diff.size() >= 4) begin
      check_val("bp_r0", {16'b0, q_diff[0]}, 32'd9);
      check_val("bp_r1", {16'b0, q_diff[1]}, 32'd18);
      check_val("bp_r2", {16'b0, q_diff[2]}, 32'd27);
      check_val("bp_r3", {16'b0, q_diff[3]}, 32'd36);
    end

    // ---- asynchronous reset with both stages full ----
    clear_q();
    out_ready = 1'b0;
    send(16'd100, 16'd1, 1'b0);
    send(16'd200, 16'd2, 1'b0);
    check_val("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    check_val("pre_rst_diff", {16'b0, diff}, 32'd99);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("mid_rst_diff", {16'b0, diff}, 32'h0);
    check_val("mid_rst_bout", {31'b0, bout}, 32'd0);
    check_val("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("no_stale_result", q_diff.size(), 32'd0);

    // ---- random stream with random stalls on both sides ----
    clear_q();
    e_diff.delete();
    e_bout.delete();
    e_ovf.delete();
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [15:0] ra;
          logic [15:0] rb;
          logic        rbin;
          int          e;
          logic [31:0] ev;
          ra   = 16'($urandom_range(0, 65535));
          rb   = 16'($urandom_range(0, 65535));
          rbin = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(ra, rb, rbin);
          e  = int'(ra) - int'(rb) - int'(rbin);
          ev = e;
          e_diff.push_back(ev[15:0]);
          e_bout.push_back(e < 0);
          e_ovf.push_back((ra[15] != rb[15]) && (ev[15] != ra[15]));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(10000, 200);
    for (int i = 0; i < 10000 && i < q_diff.size(); i++) begin
      check_val("rnd_diff", {16'b0, q_diff[i]}, {16'b0, e_diff[i]});
      check_val("rnd_bout", {31'b0, q_bout[i]}, {31'b0, e_bout[i]});
`ifdef CSS_SIGNED_OVF_EN
      check_val("rnd_ovf", {31'b0, q_ovf[i]}, {31'b0, e_ovf[i]});
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
